branch_resolution_unit: RTL and testbench

- MEM-stage consumer of the branch predictor's output. Compares the propagated prediction bit and predicted target against the actual branch outcome.
- Drives `branch_taken` back to the predictor's table-update port.
- On a misprediction, issues a one-cycle redirect PC and holds a multi-cycle flush of the younger pipeline stages (IF/ID/EX).

---
 rtl/bru_pkg.sv | 15 +
 rtl/bru_sat_counter.sv | 20 ++
 rtl/branch_resolution_unit.sv | 130 +++++++++++++
 tb/tb_branch_resolution_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared constants and FSM state type for the branch resolution unit.
package bru_pkg;

  localparam int CTRL_JAL    = 0;
  localparam int CTRL_BRANCH = 4;
  localparam int CTRL_JALR   = 13;

  localparam int PC_INC = 4;

  typedef enum logic {
    IDLE,
    FLUSH
  } bru_state_t;

endpackage

// File: rtl/bru_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module bru_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Holding at all-ones keeps a long run from wrapping back to a small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// MEM-stage branch resolution: reports actual outcome, redirects fetch and holds a flush on mispredict.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolution_unit
  import bru_pkg::*;
#(
  parameter int SIZE        = 32,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             valid_MEM,
  input  logic [13:0]      control_registers_MEM,
  input  logic             cond_true,
  input  logic             prediction,
  input  logic [SIZE-1:0]  pred_target_MEM,
  input  logic [SIZE-1:0]  PC_MEM,
  input  logic [SIZE-1:0]  jump_address,
  output logic             branch_taken,
  output logic             redirect_valid,
  output logic [SIZE-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [3:0]      FLUSH_LAST = 4'(FLUSH_DEPTH - 1);
  localparam logic [SIZE-1:0] PC_STEP    = SIZE'(PC_INC);

  bru_state_t      state;
  bru_state_t      state_next;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic            redirect_valid_next;
  logic [SIZE-1:0] redirect_pc_next;
  logic            flush_next;

  logic            is_jal;
  logic            is_jalr;
  logic            is_cond;
  logic            actual;
  logic            live;
  logic            mispredict;
  logic [SIZE-1:0] correct_target;
  logic            unused_ctrl;

  assign is_jal  = control_registers_MEM[CTRL_JAL];
  assign is_jalr = control_registers_MEM[CTRL_JALR];
  assign is_cond = control_registers_MEM[CTRL_BRANCH];
  assign unused_ctrl = ^{control_registers_MEM[12:5], control_registers_MEM[3:1]};

  // Only an unstalled, real instruction outside the flush window may resolve.
  assign actual         = is_jal | is_jalr | (is_cond & cond_true);
  assign live           = valid_MEM & ~stall & (state == IDLE);
  assign branch_taken   = live & actual;
  assign mispredict     = live & (prediction ? (~actual | (pred_target_MEM != jump_address))
                                             : actual);
  assign correct_target = actual ? jump_address : PC_MEM + PC_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      redirect_valid <= redirect_valid_next;
      redirect_pc    <= redirect_pc_next;
      flush          <= flush_next;
    end
  end

  // cnt counts down the remaining flush cycles after the first one.
  always_comb begin
    state_next          = state;
    cnt_next            = cnt;
    redirect_valid_next = 1'b0;
    redirect_pc_next    = redirect_pc;
    flush_next          = 1'b0;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_next          = FLUSH;
          cnt_next            = FLUSH_LAST;
          redirect_valid_next = 1'b1;
          redirect_pc_next    = correct_target;
          flush_next          = 1'b1;
        end
      end
      FLUSH: begin
        flush_next = 1'b1;
        if (cnt == 4'd0) begin
          state_next = IDLE;
          flush_next = 1'b0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BRU_PERF_CNT_EN
  logic is_branch;

  assign is_branch = is_jal | is_jalr | is_cond;

  bru_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (live & is_branch),
    .count (branch_count)
  );

  bru_sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict),
    .count (mispredict_count)
  );
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed scenarios plus randomized traffic against a cycle model.
module tb_branch_resolution_unit;

  localparam int SIZE = 32;
  localparam int FD   = 3;
  localparam int CW   = 4;
  localparam logic [CW-1:0] CMAX = '1;

  localparam logic [13:0] C_NONE  = 14'h0100;
  localparam logic [13:0] C_JAL   = 14'h0001;
  localparam logic [13:0] C_BR    = 14'h0010;
  localparam logic [13:0] C_JALR  = 14'h2000;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            valid_MEM;
  logic [13:0]     ctrl;
  logic            cond_true;
  logic            prediction;
  logic [SIZE-1:0] pred_target_MEM;
  logic [SIZE-1:0] PC_MEM;
  logic [SIZE-1:0] jump_address;
  logic            branch_taken;
  logic            redirect_valid;
  logic [SIZE-1:0] redirect_pc;
  logic            flush;
  logic [CW-1:0]   branch_count;
  logic [CW-1:0]   mispredict_count;

  int checks = 0;
  int errors = 0;

  int            m_left = 0;
  logic          m_rv   = 1'b0;
  logic [31:0]   m_rpc  = 32'd0;
  logic [CW-1:0] m_bc   = '0;
  logic [CW-1:0] m_mc   = '0;
  logic          m_bt   = 1'b0;
  logic          obs_bt = 1'b0;

  branch_resolution_unit #(.SIZE(SIZE), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .stall                 (stall),
    .valid_MEM             (valid_MEM),
    .control_registers_MEM (ctrl),
    .cond_true             (cond_true),
    .prediction            (prediction),
    .pred_target_MEM       (pred_target_MEM),
    .PC_MEM                (PC_MEM),
    .jump_address          (jump_address),
    .branch_taken          (branch_taken),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .flush                 (flush),
    .branch_count          (branch_count),
    .mispredict_count      (mispredict_count)
  );

  always #5 clk = ~clk;

  task drive(input logic v, input logic st, input logic [13:0] c, input logic ct,
             input logic p, input logic [31:0] pt, input logic [31:0] pc, input logic [31:0] ja);
    valid_MEM       = v;
    stall           = st;
    ctrl            = c;
    cond_true       = ct;
    prediction      = p;
    pred_target_MEM = pt;
    PC_MEM          = pc;
    jump_address    = ja;
  endtask

  // Advances one clock: samples branch_taken before the edge and updates the model at the edge.
  task step();
    logic act, isb, live, mis;
    #1;
    act  = ctrl[0] | ctrl[13] | (ctrl[4] & cond_true);
    isb  = ctrl[0] | ctrl[13] | ctrl[4];
    live = valid_MEM && !stall && (m_left == 0);
    mis  = live && (prediction ? (!act || (pred_target_MEM != jump_address)) : act);
    m_bt   = live && act;
    obs_bt = branch_taken;
    @(posedge clk);
    if (reset) begin
      m_left = 0;
      m_rv   = 1'b0;
      m_rpc  = 32'd0;
      m_bc   = '0;
      m_mc   = '0;
    end else begin
      if (m_left > 0) begin
        m_left = m_left - 1;
        m_rv   = 1'b0;
      end else if (mis) begin
        m_left = FD;
        m_rv   = 1'b1;
        m_rpc  = act ? jump_address : PC_MEM + 32'd4;
      end else begin
        m_rv = 1'b0;
      end
`ifdef BRU_PERF_CNT_EN
      if (live && isb && (m_bc != CMAX)) m_bc = m_bc + 1'b1;
      if (mis && (m_mc != CMAX)) m_mc = m_mc + 1'b1;
`endif
    end
    @(negedge clk);
  endtask

  task test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    step();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rv: got %b want 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_rpc: got %h want 0", redirect_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush: got %b want 0", flush); end
    checks++; if (branch_count !== '0) begin errors++; $display("[TB] FAIL reset_bc: got %0d want 0", branch_count); end
    checks++; if (mispredict_count !== '0) begin errors++; $display("[TB] FAIL reset_mc: got %0d want 0", mispredict_count); end
    reset = 1'b0;
    step();
  endtask

  task test_correct_predict();
    drive(1'b1, 1'b0, C_BR, 1'b1, 1'b1, 32'h140, 32'h100, 32'h140);
    step();
    checks++; if (obs_bt !== 1'b1) begin errors++; $display("[TB] FAIL cp_bt: got %b want 1", obs_bt); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL cp_rv: got %b want 0", redirect_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL cp_flush: got %b want 0", flush); end
    checks++; if (branch_count !== m_bc) begin errors++; $display("[TB] FAIL cp_bc: got %0d want %0d", branch_count, m_bc); end
    drive(1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 32'd0, 32'h104, 32'd0);
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL cp_flush2: got %b want 0", flush); end
  endtask

  task test_mispredict_not_taken();
    drive(1'b1, 1'b0, C_BR, 1'b0, 1'b1, 32'h140, 32'h100, 32'h140);
    step();
    checks++; if (obs_bt !== 1'b0) begin errors++; $display("[TB] FAIL mnt_bt: got %b want 0", obs_bt); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL mnt_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("[TB] FAIL mnt_rpc: got %h want 00000104", redirect_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL mnt_flush: got %b want 1", flush); end
    drive(1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (flush !== (i < 2)) begin errors++; $display("[TB] FAIL mnt_flush_tail%0d: got %b want %b", i, flush, (i < 2)); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL mnt_rv_tail%0d: got %b want 0", i, redirect_valid); end
      checks++; if (redirect_pc !== 32'h104) begin errors++; $display("[TB] FAIL mnt_rpc_hold%0d: got %h want 00000104", i, redirect_pc); end
    end
    checks++; if (mispredict_count !== m_mc) begin errors++; $display("[TB] FAIL mnt_mc: got %0d want %0d", mispredict_count, m_mc); end
  endtask

  task test_jalr_flush_window();
    drive(1'b1, 1'b0, C_JALR, 1'b0, 1'b1, 32'h280, 32'h200, 32'h300);
    step();
    checks++; if (obs_bt !== 1'b1) begin errors++; $display("[TB] FAIL jalr_bt: got %b want 1", obs_bt); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL jalr_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h300) begin errors++; $display("[TB] FAIL jalr_rpc: got %h want 00000300", redirect_pc); end
    drive(1'b1, 1'b0, C_BR, 1'b1, 1'b0, 32'd0, 32'h400, 32'h500);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (obs_bt !== 1'b0) begin errors++; $display("[TB] FAIL jalr_wp_bt%0d: got %b want 0", i, obs_bt); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL jalr_wp_rv%0d: got %b want 0", i, redirect_valid); end
      checks++; if (redirect_pc !== 32'h300) begin errors++; $display("[TB] FAIL jalr_wp_rpc%0d: got %h want 00000300", i, redirect_pc); end
      checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL jalr_wp_flush%0d: got %b want 1", i, flush); end
    end
    drive(1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL jalr_end_flush: got %b want 0", flush); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL jalr_end_rv: got %b want 0", redirect_valid); end
  endtask

  task test_wraparound();
    drive(1'b1, 1'b0, C_NONE, 1'b1, 1'b1, 32'h1234, 32'hFFFF_FFFC, 32'h8);
    step();
    checks++; if (obs_bt !== 1'b0) begin errors++; $display("[TB] FAIL wrap_bt: got %b want 0", obs_bt); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_rpc: got %h want 00000000", redirect_pc); end
    drive(1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < FD; i++) step();
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL wrap_end_flush: got %b want 0", flush); end
  endtask

  task test_stall();
    drive(1'b1, 1'b1, C_BR, 1'b1, 1'b1, 32'h640, 32'h600, 32'h640);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (obs_bt !== 1'b0) begin errors++; $display("[TB] FAIL stall_bt%0d: got %b want 0", i, obs_bt); end
      checks++; if (branch_count !== m_bc) begin errors++; $display("[TB] FAIL stall_bc%0d: got %0d want %0d", i, branch_count, m_bc); end
    end
    stall = 1'b0;
    step();
    checks++; if (obs_bt !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_bt: got %b want 1", obs_bt); end
    checks++; if (branch_count !== m_bc) begin errors++; $display("[TB] FAIL stall_release_bc: got %0d want %0d", branch_count, m_bc); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_rv: got %b want 0", redirect_valid); end
    valid_MEM = 1'b0;
    step();
    checks++; if (branch_count !== m_bc) begin errors++; $display("[TB] FAIL stall_after_bc: got %0d want %0d", branch_count, m_bc); end
  endtask

  task test_reset_in_flush();
    drive(1'b1, 1'b0, C_BR, 1'b1, 1'b0, 32'd0, 32'h700, 32'h740);
    step();
    drive(1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL rif_pre_flush: got %b want 1", flush); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL rif_flush: got %b want 0", flush); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL rif_rv: got %b want 0", redirect_valid); end
    checks++; if (branch_count !== '0) begin errors++; $display("[TB] FAIL rif_bc: got %0d want 0", branch_count); end
    checks++; if (mispredict_count !== '0) begin errors++; $display("[TB] FAIL rif_mc: got %0d want 0", mispredict_count); end
    drive(1'b1, 1'b0, C_JAL, 1'b0, 1'b0, 32'd0, 32'h800, 32'h900);
    step();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL rif_next_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h900) begin errors++; $display("[TB] FAIL rif_next_rpc: got %h want 00000900", redirect_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL rif_next_flush: got %b want 1", flush); end
    drive(1'b0, 1'b0, C_NONE, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < FD; i++) step();
  endtask

  task test_random();
    logic [13:0] c;
    logic [31:0] ja;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       c = C_NONE;
        1:       c = C_JAL;
        2:       c = C_JALR;
        3:       c = C_BR;
        default: c = 14'h0FEE;
      endcase
      ja = $urandom() & 32'hFFFF_FFFC;
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0), c, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? ja : ($urandom() & 32'hFFFF_FFFC),
            $urandom() & 32'hFFFF_FFFC, ja);
      reset = ($urandom_range(0, 59) == 0);
      step();
      checks++; if (obs_bt !== m_bt) begin errors++; $display("[TB] FAIL rnd_bt@%0d: got %b want %b", n, obs_bt, m_bt); end
      checks++; if (redirect_valid !== m_rv) begin errors++; $display("[TB] FAIL rnd_rv@%0d: got %b want %b", n, redirect_valid, m_rv); end
      checks++; if (redirect_pc !== m_rpc) begin errors++; $display("[TB] FAIL rnd_rpc@%0d: got %h want %h", n, redirect_pc, m_rpc); end
      checks++; if (flush !== (m_left > 0)) begin errors++; $display("[TB] FAIL rnd_flush@%0d: got %b want %b", n, flush, (m_left > 0)); end
      checks++; if (branch_count !== m_bc) begin errors++; $display("[TB] FAIL rnd_bc@%0d: got %0d want %0d", n, branch_count, m_bc); end
      checks++; if (mispredict_count !== m_mc) begin errors++; $display("[TB] FAIL rnd_mc@%0d: got %0d want %0d", n, mispredict_count, m_mc); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_correct_predict();
    test_mispredict_not_taken();
    test_jalr_flush_window();
    test_wraparound();
    test_stall();
    test_reset_in_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
